udc_host_sequencer: RTL and testbench
=====================================

# udc_host_sequencer

Bus-master stage that sits directly upstream of the up/down counter. It takes one configuration command per run: preset, upper limit, lower limit and cycle count. It programs the counter's four registers over the counter's 8-bit bidirectional bus (din/ncs/nrd/nwr/a0/a1), can optionally read them back to verify, then pulses start. It waits for end-of-count (ec) or range error (err) and reports a single completion status to the host.

## Interface
Parameters:
- TIMEOUT, 4096: max cycles spent in RUN waiting for ec before aborting; legal range 1..65535 (16-bit counter).

Ports:
- clk  input  1  single clock; all logic on posedge.
- reset  input  1  synchronous, active-high.
- cmd_valid  input  1  host command valid.
- cmd_ready  output  1  high only in IDLE.
- cmd_plr  input  8  preset value.
- cmd_ulr  input  8  upper limit.
- cmd_llr  input  8  lower limit.
- cmd_ccr  input  8  cycle count.
- cmd_verify  input  1  1 = read back all four registers before start.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- status  output  2  valid while done=1: 00 ok, 01 range err, 10 verify mismatch, 11 timeout.
- din  inout  8  counter data bus; driven only during write cycles, else 8'hz.
- ncs, nrd, nwr  output  1  active-low bus strobes to the counter.
- a0, a1  output  1  register address: {a1,a0} 00=PLR, 01=ULR, 10=LLR, 11=CCR.
- start  output  1  one-cycle start pulse to the counter.
- ec, err  input  1  counter end-of-count and error flags, both registered in the counter.

## Operation
- States: IDLE, WR, WR_GAP, RD, RD_GAP, START, CHK, RUN, DONE.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch all cmd_* fields, set idx=0, go to WR. cmd_valid outside IDLE is ignored.
- WR: ncs=0, nwr=0, nrd=1, {a1,a0}=idx, din driven with the latched register selected by idx. Next state is WR_GAP.
- WR_GAP: all strobes high, bus released. If idx<3, increment idx and return to WR. If idx=3: go to RD with idx=0 when verify=1, else go to START.
- RD: ncs=0, nrd=0, nwr=1, {a1,a0}=idx, din tri-stated. Sample din into rd_q on the closing edge.
- RD_GAP: strobes high. Compare rd_q with the latched value for idx.
  - Mismatch: status=10, go to DONE. start is never asserted.
  - Match and idx<3: increment idx, go to RD.
  - Match and idx=3: go to START.
- START: start=1 for exactly one cycle, strobes high. Go to CHK.
- CHK: one cycle for the counter's err/ec to update. err=1 sets status=01 and goes to DONE. Otherwise clear the timeout counter and go to RUN.
- RUN: ec=1 sets status=00 and goes to DONE; err=1 sets status=01 and goes to DONE. If the timeout counter reaches TIMEOUT-1 with neither flag set, status=11 and go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- nrd and nwr are never low in the same cycle; the counter treats that combination as special.
- Any path that does not pass through START leaves start low.
- No address or data changes while a strobe is low; every access is exactly one strobe cycle followed by one gap cycle.

## Timing
- Reset values: cmd_ready=1, busy=0, done=0, status=00, ncs=nrd=nwr=1, a0=a1=0, start=0, din=8'hz, state IDLE. Internal idx, latches and timeout counter are all 0.
- Reset mid-operation: on the next edge all outputs take their reset values and the bus is released. No partial start pulse is issued.
- All outputs are registered. Cycle 0 is the accept edge.
- Without verify:
  - Write strobes in cycles 1, 3, 5, 7.
  - start in cycle 9, CHK in cycle 10, RUN from cycle 11.
  - Earliest done (err) in cycle 11.
- With verify:
  - Reads in cycles 9, 11, 13, 15.
  - start in cycle 17.
  - A mismatch at read k (k=0..3) gives done at cycle 11+2k.
- From RUN, done follows the ec/err/timeout detection edge by one cycle.
- Timeout fires exactly TIMEOUT cycles after entering RUN.
- A stale ec=1 from a previous run is cleared by the counter on the start edge, so RUN never sees it.
- If a timeout leaves the counter still running, the counter ignores the next command's writes. That case is caught only when verify=1.
- cmd_ready returns high the cycle after DONE; back-to-back commands are therefore spaced at least one IDLE cycle apart.

## Test plan
- Basic run: PLR=05, ULR=08, LLR=02, CCR=01, verify=0, with the real counter attached.
  - Writes in cycles 1/3/5/7 with {a1,a0}=00/01/10/11 and data 05/08/02/01.
  - start high only in cycle 9.
  - done with status=00 one cycle after ec rises.
- Range error: PLR=20, ULR=10, LLR=00, CCR=02 -> err seen in CHK -> done in cycle 11 with status=01.
- Verify: PLR=40, ULR=50, LLR=30, CCR=03, verify=1.
  - Pass case: reads in cycles 9/11/13/15 return the written values; start in cycle 17.
  - Mismatch case: bench forces din=FF during read 2 -> done in cycle 15 with status=10, start never high.
- Timeout: TIMEOUT=16, stub counter that never raises ec or err -> done 16 cycles after RUN entry with status=11.
- Reset mid-write: assert reset during cycle 3 (ULR strobe).
  - Next cycle: ncs=nwr=nrd=1, din=z, busy=0, cmd_ready=1, start=0.
  - A new command then completes normally.
- Back-to-back: cmd_valid held high continuously for two commands.
  - Only one is accepted per IDLE visit.
  - The second begins writing two cycles after the first's done.
  - No nrd/nwr overlap occurs anywhere in the trace.

Source files
------------

// File: rtl/udc_host_sequencer.sv
// udc_host_sequencer: programs the up/down counter over its 8-bit bus,
// optionally verifies by readback, starts it and reports completion.
module udc_host_sequencer #(
  parameter int TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_plr,
  input  logic [7:0] cmd_ulr,
  input  logic [7:0] cmd_llr,
  input  logic [7:0] cmd_ccr,
  input  logic       cmd_verify,
  output logic       busy,
  output logic       done,
  output logic [1:0] status,
  inout  wire  [7:0] din,
  output logic       ncs,
  output logic       nrd,
  output logic       nwr,
  output logic       a0,
  output logic       a1,
  output logic       start,
  input  logic       ec,
  input  logic       err
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR, S_WR_GAP, S_RD, S_RD_GAP,
    S_START, S_CHK, S_RUN, S_DONE
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t     state_q;
  logic [7:0] reg_q [4];
  logic [1:0] idx_q;
  logic [1:0] idx_d;
  logic       verify_q;
  logic [7:0] rd_q;
  logic [7:0] dout_q;
  logic       drv_q;
  logic [15:0] tmo_q;
  logic       ready_q;
  logic       busy_q;
  logic       done_q;
  logic       ncs_q;
  logic       nrd_q;
  logic       nwr_q;
  logic       start_q;
  logic [1:0] addr_q;
  logic [1:0] status_q;

  assign idx_d     = idx_q + 2'd1;
  assign din       = drv_q ? dout_q : 8'hzz;
  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign status    = status_q;
  assign ncs       = ncs_q;
  assign nrd       = nrd_q;
  assign nwr       = nwr_q;
  assign a0        = addr_q[0];
  assign a1        = addr_q[1];
  assign start     = start_q;

  // Outputs are loaded for the state being entered, so every
  // strobe, address and data value is a flop output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      for (int i = 0; i < 4; i++) reg_q[i] <= 8'h00;
      idx_q    <= 2'd0;
      verify_q <= 1'b0;
      rd_q     <= 8'h00;
      dout_q   <= 8'h00;
      drv_q    <= 1'b0;
      tmo_q    <= 16'd0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ncs_q    <= 1'b1;
      nrd_q    <= 1'b1;
      nwr_q    <= 1'b1;
      start_q  <= 1'b0;
      addr_q   <= 2'd0;
      status_q <= 2'b00;
    end else begin
      ncs_q   <= 1'b1;
      nrd_q   <= 1'b1;
      nwr_q   <= 1'b1;
      drv_q   <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            reg_q[0] <= cmd_plr;
            reg_q[1] <= cmd_ulr;
            reg_q[2] <= cmd_llr;
            reg_q[3] <= cmd_ccr;
            verify_q <= cmd_verify;
            idx_q    <= 2'd0;
            addr_q   <= 2'd0;
            dout_q   <= cmd_plr;
            drv_q    <= 1'b1;
            ncs_q    <= 1'b0;
            nwr_q    <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= S_WR;
          end
        end
        S_WR: state_q <= S_WR_GAP;
        S_WR_GAP: begin
          if (idx_q != 2'd3) begin
            idx_q   <= idx_d;
            addr_q  <= idx_d;
            dout_q  <= reg_q[idx_d];
            drv_q   <= 1'b1;
            ncs_q   <= 1'b0;
            nwr_q   <= 1'b0;
            state_q <= S_WR;
          end else if (verify_q) begin
            idx_q   <= 2'd0;
            addr_q  <= 2'd0;
            ncs_q   <= 1'b0;
            nrd_q   <= 1'b0;
            state_q <= S_RD;
          end else begin
            start_q <= 1'b1;
            state_q <= S_START;
          end
        end
        S_RD: begin
          rd_q    <= din;
          state_q <= S_RD_GAP;
        end
        S_RD_GAP: begin
          if (rd_q != reg_q[idx_q]) begin
            status_q <= 2'b10;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else if (idx_q != 2'd3) begin
            idx_q   <= idx_d;
            addr_q  <= idx_d;
            ncs_q   <= 1'b0;
            nrd_q   <= 1'b0;
            state_q <= S_RD;
          end else begin
            start_q <= 1'b1;
            state_q <= S_START;
          end
        end
        S_START: state_q <= S_CHK;
        S_CHK: begin
          if (err) begin
            status_q <= 2'b01;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            tmo_q   <= 16'd0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (err) begin
            status_q <= 2'b01;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else if (ec) begin
            status_q <= 2'b00;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else if (tmo_q == TMO_LAST) begin
            status_q <= 2'b11;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            tmo_q <= tmo_q + 16'd1;
          end
        end
        S_DONE: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udc_host_sequencer.sv
// Bench for udc_host_sequencer: stub counter on the bus, table of
// directed runs, randomized runs against a cycle-level outcome model.
module tb_udc_host_sequencer;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_plr = 8'h00;
  logic [7:0] cmd_ulr = 8'h00;
  logic [7:0] cmd_llr = 8'h00;
  logic [7:0] cmd_ccr = 8'h00;
  logic       cmd_verify = 1'b0;
  logic       cmd_ready, busy, done;
  logic [1:0] status;
  logic       ncs, nrd, nwr, a0, a1, start;
  logic       ec, err;
  wire  [7:0] din;

  always #5 clk = ~clk;

  udc_host_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_plr(cmd_plr), .cmd_ulr(cmd_ulr),
    .cmd_llr(cmd_llr), .cmd_ccr(cmd_ccr),
    .cmd_verify(cmd_verify),
    .busy(busy), .done(done), .status(status),
    .din(din), .ncs(ncs), .nrd(nrd), .nwr(nwr),
    .a0(a0), .a1(a1), .start(start),
    .ec(ec), .err(err)
  );

  // Released bus reads as FF.
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (din[i]);
  end

  // Stub counter: kind 0 never flags, 1 raises ec, 2 raises err,
  // the flag becomes visible cfg_d cycles after the start cycle.
  int         cfg_kind = 0;
  int         cfg_d = 1;
  int         cfg_corrupt = -1;
  logic [7:0] sreg [4];
  logic [7:0] rdat;
  int         sc;
  bit         srun;

  always_comb begin
    rdat = sreg[{a1, a0}];
    if (cfg_corrupt == int'({a1, a0}))
      rdat = (sreg[{a1, a0}] == 8'hFF) ? 8'h00 : 8'hFF;
  end
  assign din = (!ncs && !nrd) ? rdat : 8'hzz;

  always @(posedge clk) begin
    if (reset) begin
      ec <= 1'b0; err <= 1'b0; srun <= 1'b0; sc <= 0;
    end else begin
      if (!ncs && !nwr) sreg[{a1, a0}] <= din;
      if (start) begin
        ec <= 1'b0; err <= 1'b0; srun <= 1'b1; sc <= 2;
        if (cfg_d == 1) begin
          if (cfg_kind == 1) ec <= 1'b1;
          if (cfg_kind == 2) err <= 1'b1;
        end
      end else if (srun) begin
        sc <= sc + 1;
        if (sc == cfg_d) begin
          if (cfg_kind == 1) ec <= 1'b1;
          if (cfg_kind == 2) err <= 1'b1;
        end
      end
    end
  end

  typedef struct {
    logic [7:0] plr, ulr, llr, ccr;
    bit         verify;
    int         corrupt;
    int         kind;
    int         d;
    logic [1:0] st;
    int         dn;
    string      name;
  } vec_t;

  int checks = 0;
  int passed = 0;

  task automatic chk(input bit ok, input string nm, input int k,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s cyc=%0d got=%h want=%h", nm, k, act, exp);
  endtask

  function automatic logic [7:0] fld(input vec_t v, input int i);
    case (i)
      0: return v.plr;
      1: return v.ulr;
      2: return v.llr;
      default: return v.ccr;
    endcase
  endfunction

  // Outcome from the rules: done cycle and status, counted from accept.
  function automatic vec_t model(input vec_t vi);
    vec_t v;
    int base, vis;
    v = vi;
    base = v.verify ? 17 : 9;
    vis = base + v.d;
    if (v.verify && v.corrupt >= 0) begin
      v.dn = 11 + 2 * v.corrupt; v.st = 2'b10;
    end else if (v.kind == 2 && vis == base + 1) begin
      v.dn = base + 2; v.st = 2'b01;
    end else if (v.kind != 0 && vis <= base + 1 + TO) begin
      v.dn = ((vis < base + 2) ? base + 2 : vis) + 1;
      v.st = (v.kind == 1) ? 2'b00 : 2'b01;
    end else begin
      v.dn = base + 2 + TO; v.st = 2'b11;
    end
    return v;
  endfunction

  // Expected bus access in cycle k: 0 none, 1 write, 2 read.
  function automatic int acc(input vec_t v, input int k, output int ai);
    ai = 0;
    if (k >= 1 && k <= 7 && k % 2 == 1) begin
      ai = (k - 1) / 2; return 1;
    end
    if (v.verify && k >= 9 && k <= 15 && k % 2 == 1 && k < v.dn) begin
      ai = (k - 9) / 2; return 2;
    end
    return 0;
  endfunction

  task automatic check_cycle(input vec_t v, input int k);
    int ak, ai, base;
    logic [6:0] e, a;
    base = v.verify ? 17 : 9;
    ak = acc(v, k, ai);
    e = {k > v.dn, k <= v.dn, k == v.dn, ak == 0, ak != 2, ak != 1,
         v.st != 2'b10 && k == base};
    a = {cmd_ready, busy, done, ncs, nrd, nwr, start};
    chk(a == e, {v.name, ".ctl"}, k, 32'(a), 32'(e));
    if (ak != 0)
      chk({a1, a0} == ai[1:0], {v.name, ".addr"}, k,
          32'({a1, a0}), 32'(ai));
    if (ak == 1)
      chk(din == fld(v, ai), {v.name, ".wdata"}, k,
          32'(din), 32'(fld(v, ai)));
    else if (ak == 0)
      chk(din == 8'hFF, {v.name, ".bus_rel"}, k, 32'(din), 32'hFF);
    if (k == v.dn)
      chk(status == v.st, {v.name, ".status"}, k,
          32'(status), 32'(v.st));
  endtask

  // Called at a negedge with the sequencer idle; returns at the
  // negedge of the first idle cycle after done.
  task automatic run_one(input vec_t v, input bit keep);
    cfg_kind    = v.kind;
    cfg_d       = v.d;
    cfg_corrupt = v.verify ? v.corrupt : -1;
    cmd_plr = v.plr; cmd_ulr = v.ulr;
    cmd_llr = v.llr; cmd_ccr = v.ccr;
    cmd_verify = v.verify;
    cmd_valid  = 1'b1;
    chk(cmd_ready == 1'b1, {v.name, ".ready"}, 0, 32'(cmd_ready), 32'd1);
    for (int k = 1; k <= v.dn + 1; k++) begin
      @(negedge clk);
      if (k == 1 && !keep) cmd_valid = 1'b0;
      check_cycle(v, k);
    end
  endtask

  vec_t tbl [13];
  vec_t v;

  initial begin
    tbl[0]  = '{8'h05, 8'h08, 8'h02, 8'h01, 1'b0, -1, 1, 4,  2'b00, 14, "basic"};
    tbl[1]  = '{8'h20, 8'h10, 8'h00, 8'h02, 1'b0, -1, 2, 1,  2'b01, 11, "range"};
    tbl[2]  = '{8'h40, 8'h50, 8'h30, 8'h03, 1'b1, -1, 1, 3,  2'b00, 21, "vpass"};
    tbl[3]  = '{8'h40, 8'h50, 8'h30, 8'h03, 1'b1,  2, 1, 3,  2'b10, 15, "vmis2"};
    tbl[4]  = '{8'h11, 8'h22, 8'h33, 8'h44, 1'b0, -1, 0, 5,  2'b11, 27, "tmo"};
    tbl[5]  = '{8'h05, 8'h08, 8'h02, 8'h01, 1'b0, -1, 1, 1,  2'b00, 12, "ecchk"};
    tbl[6]  = '{8'h05, 8'h08, 8'h02, 8'h01, 1'b0, -1, 2, 5,  2'b01, 15, "errrun"};
    tbl[7]  = '{8'h05, 8'h08, 8'h02, 8'h01, 1'b0, -1, 1, 17, 2'b00, 27, "eclast"};
    tbl[8]  = '{8'h05, 8'h08, 8'h02, 8'h01, 1'b0, -1, 1, 18, 2'b11, 27, "eclate"};
    tbl[9]  = '{8'hA5, 8'h5A, 8'h00, 8'hFF, 1'b1,  0, 1, 3,  2'b10, 11, "vmis0"};
    tbl[10] = '{8'hA5, 8'h5A, 8'h00, 8'h7E, 1'b1,  3, 1, 3,  2'b10, 17, "vmis3"};
    tbl[11] = '{8'h01, 8'h02, 8'h03, 8'h04, 1'b1, -1, 0, 1,  2'b11, 35, "vtmo"};
    tbl[12] = '{8'h01, 8'h02, 8'h03, 8'h04, 1'b1, -1, 2, 1,  2'b01, 19, "verr"};

    repeat (3) @(negedge clk);
    chk({cmd_ready, busy, done, status, ncs, nrd, nwr, a1, a0, start}
        == 11'b100_00_111_00_0, "reset_state", 0,
        32'({cmd_ready, busy, done, status, ncs, nrd, nwr, a1, a0, start}),
        32'b100_00_111_00_0);
    chk(din == 8'hFF, "reset_bus", 0, 32'(din), 32'hFF);
    reset = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) run_one(tbl[i], 1'b0);

    // Reset during the ULR write strobe.
    v = tbl[0];
    v.name = "rstmid";
    cfg_kind = 1; cfg_d = 4; cfg_corrupt = -1;
    cmd_plr = v.plr; cmd_ulr = v.ulr; cmd_llr = v.llr; cmd_ccr = v.ccr;
    cmd_verify = 1'b0;
    cmd_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) cmd_valid = 1'b0;
      check_cycle(v, k);
    end
    reset = 1'b1;
    @(negedge clk);
    chk({cmd_ready, busy, done, ncs, nrd, nwr, start} == 7'b1001110,
        "rstmid.outs", 4,
        32'({cmd_ready, busy, done, ncs, nrd, nwr, start}), 32'b1001110);
    chk(din == 8'hFF, "rstmid.bus", 4, 32'(din), 32'hFF);
    reset = 1'b0;
    @(negedge clk);
    run_one(tbl[0], 1'b0);

    // Back-to-back with cmd_valid held high throughout.
    run_one(tbl[0], 1'b1);
    run_one(tbl[2], 1'b0);

    for (int n = 0; n < 24; n++) begin
      v.plr = 8'($urandom);
      v.ulr = 8'($urandom);
      v.llr = 8'($urandom);
      v.ccr = 8'($urandom);
      v.verify = 1'($urandom);
      v.corrupt = (v.verify && $urandom_range(0, 2) == 0)
                  ? int'($urandom_range(0, 3)) : -1;
      v.kind = int'($urandom_range(0, 2));
      v.d = int'($urandom_range(1, 20));
      v.name = "rand";
      v = model(v);
      run_one(v, 1'($urandom_range(0, 1)));
      cmd_valid = 1'b0;
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
